tl_a_arbiter_2to1: RTL and testbench

// Two-master TileLink arbiter placed directly upstream of the L2 slave adapter. It merges the
// A-channel requests of two masters (m0, m1) into the single slave A port, one transaction in

---
 rtl/tl_a_arbiter_2to1_if.sv | 43 ++++
 rtl/tl_a_arbiter_2to1.sv | 181 ++++++++++++++++++
 tb/tb_tl_a_arbiter_2to1.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_a_arbiter_2to1_if.sv
// TileLink A/D channel bundle shared by both arbiter master ports and the slave port.
// The master modport drives the A channel and consumes the D channel; the slave modport is the reverse.
interface tl_a_arbiter_2to1_if #(
  parameter int SIZE_W     = 3,
  parameter int SOURCE_W   = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 4,
  parameter int SINK_W     = 2
);
  logic                    a_valid;
  logic                    a_ready;
  logic [2:0]              a_opcode;
  logic [2:0]              a_param;
  logic [SIZE_W-1:0]       a_size;
  logic [SOURCE_W-1:0]     a_source;
  logic [ADDR_W-1:0]       a_address;
  logic [DATA_BYTES-1:0]   a_mask;
  logic [DATA_BYTES*8-1:0] a_data;

  logic                    d_valid;
  logic                    d_ready;
  logic [3:0]              d_opcode;
  logic [1:0]              d_param;
  logic [SIZE_W-1:0]       d_size;
  logic [SOURCE_W-1:0]     d_source;
  logic [SINK_W-1:0]       d_sink;
  logic                    d_denied;
  logic [DATA_BYTES*8-1:0] d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data,
    input  d_ready
  );
endinterface

// File: rtl/tl_a_arbiter_2to1.sv
// Two-master TileLink A-channel arbiter, one transaction in flight, D routed back by grant.
// Unsupported opcodes are answered locally with a denied AccessAck.
module tl_a_arbiter_2to1 #(
  parameter int CNT_BITS   = 16,
  parameter int SIZE_W     = 3,
  parameter int SOURCE_W   = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 4,
  parameter int SINK_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tl_a_arbiter_2to1_if.slave    m0,
  tl_a_arbiter_2to1_if.slave    m1,
  tl_a_arbiter_2to1_if.master   s,
  output logic [CNT_BITS-1:0]   grant_cnt0,
  output logic [CNT_BITS-1:0]   grant_cnt1
);
  localparam logic [2:0] TL_A_PUTFULL    = 3'd0;
  localparam logic [2:0] TL_A_PUTPARTIAL = 3'd1;
  localparam logic [2:0] TL_A_GET        = 3'd4;
  localparam logic [3:0] TL_D_ACCESSACK  = 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ERR} state_t;

  state_t                  state;
  logic                    gnt;
  logic                    rr_ptr;
  logic [2:0]              cap_opcode;
  logic [2:0]              cap_param;
  logic [SIZE_W-1:0]       cap_size;
  logic [SOURCE_W-1:0]     cap_source;
  logic [ADDR_W-1:0]       cap_address;
  logic [DATA_BYTES-1:0]   cap_mask;
  logic [DATA_BYTES*8-1:0] cap_data;

  logic win;
  logic accept;
  logic legal;
  logic g_d_ready;

  always_comb begin
    win    = (m0.a_valid && m1.a_valid) ? rr_ptr : m1.a_valid;
    accept = (state == S_IDLE) && (m0.a_valid || m1.a_valid);
    legal  = win ? (m1.a_opcode inside {TL_A_GET, TL_A_PUTFULL, TL_A_PUTPARTIAL})
                 : (m0.a_opcode inside {TL_A_GET, TL_A_PUTFULL, TL_A_PUTPARTIAL});
    g_d_ready = gnt ? m1.d_ready : m0.d_ready;
  end

  assign m0.a_ready = accept && !win;
  assign m1.a_ready = accept && win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      gnt         <= 1'b0;
      rr_ptr      <= 1'b0;
      cap_opcode  <= '0;
      cap_param   <= '0;
      cap_size    <= '0;
      cap_source  <= '0;
      cap_address <= '0;
      cap_mask    <= '0;
      cap_data    <= '0;
      grant_cnt0  <= '0;
      grant_cnt1  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            gnt         <= win;
            cap_opcode  <= win ? m1.a_opcode  : m0.a_opcode;
            cap_param   <= win ? m1.a_param   : m0.a_param;
            cap_size    <= win ? m1.a_size    : m0.a_size;
            cap_source  <= win ? m1.a_source  : m0.a_source;
            cap_address <= win ? m1.a_address : m0.a_address;
            cap_mask    <= win ? m1.a_mask    : m0.a_mask;
            cap_data    <= win ? m1.a_data    : m0.a_data;
            if (win) begin
              if (grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_BITS'(1);
            end else begin
              if (grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_BITS'(1);
            end
            state <= legal ? S_REQ : S_ERR;
          end
        end
        S_REQ: begin
          if (s.a_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (s.d_valid && g_d_ready) begin
            state  <= S_IDLE;
            rr_ptr <= ~gnt;
          end
        end
        S_ERR: begin
          if (g_d_ready) begin
            state  <= S_IDLE;
            rr_ptr <= ~gnt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Slave A port presents the captured request only while in S_REQ, zero otherwise.
  always_comb begin
    s.a_valid   = (state == S_REQ);
    s.a_opcode  = s.a_valid ? cap_opcode  : '0;
    s.a_param   = s.a_valid ? cap_param   : '0;
    s.a_size    = s.a_valid ? cap_size    : '0;
    s.a_source  = s.a_valid ? cap_source  : '0;
    s.a_address = s.a_valid ? cap_address : '0;
    s.a_mask    = s.a_valid ? cap_mask    : '0;
    s.a_data    = s.a_valid ? cap_data    : '0;
    s.d_ready   = (state == S_WAIT) && g_d_ready;
  end

  logic                    rsp_valid;
  logic [3:0]              rsp_opcode;
  logic [1:0]              rsp_param;
  logic [SIZE_W-1:0]       rsp_size;
  logic [SOURCE_W-1:0]     rsp_source;
  logic [SINK_W-1:0]       rsp_sink;
  logic                    rsp_denied;
  logic [DATA_BYTES*8-1:0] rsp_data;

  always_comb begin
    rsp_valid  = 1'b0;
    rsp_opcode = '0;
    rsp_param  = '0;
    rsp_size   = '0;
    rsp_source = '0;
    rsp_sink   = '0;
    rsp_denied = 1'b0;
    rsp_data   = '0;
    case (state)
      S_WAIT: begin
        if (s.d_valid) begin
          rsp_valid  = 1'b1;
          rsp_opcode = s.d_opcode;
          rsp_param  = s.d_param;
          rsp_size   = s.d_size;
          rsp_source = s.d_source;
          rsp_sink   = s.d_sink;
          rsp_denied = s.d_denied;
          rsp_data   = s.d_data;
        end
      end
      S_ERR: begin
        rsp_valid  = 1'b1;
        rsp_opcode = TL_D_ACCESSACK;
        rsp_denied = 1'b1;
        rsp_size   = cap_size;
        rsp_source = cap_source;
      end
      default: ;
    endcase
  end

  // Response fields are already zero when not valid, so gating by grant is sufficient.
  always_comb begin
    m0.d_valid  = rsp_valid && !gnt;
    m0.d_opcode = gnt ? '0 : rsp_opcode;
    m0.d_param  = gnt ? '0 : rsp_param;
    m0.d_size   = gnt ? '0 : rsp_size;
    m0.d_source = gnt ? '0 : rsp_source;
    m0.d_sink   = gnt ? '0 : rsp_sink;
    m0.d_denied = gnt ? 1'b0 : rsp_denied;
    m0.d_data   = gnt ? '0 : rsp_data;
    m1.d_valid  = rsp_valid && gnt;
    m1.d_opcode = gnt ? rsp_opcode : '0;
    m1.d_param  = gnt ? rsp_param  : '0;
    m1.d_size   = gnt ? rsp_size   : '0;
    m1.d_source = gnt ? rsp_source : '0;
    m1.d_sink   = gnt ? rsp_sink   : '0;
    m1.d_denied = gnt ? rsp_denied : 1'b0;
    m1.d_data   = gnt ? rsp_data   : '0;
  end
endmodule

// File: tb/tb_tl_a_arbiter_2to1.sv
// Scoreboard bench for tl_a_arbiter_2to1: directed requests push expected slave-A and
// per-master D responses; monitors pop and compare on every handshake.
module tb_tl_a_arbiter_2to1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] grant_cnt0, grant_cnt1;

  always #5 clk = ~clk;

  tl_a_arbiter_2to1_if m0();
  tl_a_arbiter_2to1_if m1();
  tl_a_arbiter_2to1_if s();

  tl_a_arbiter_2to1 #(.CNT_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0), .m1(m1), .s(s),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  typedef struct packed {
    logic [2:0] op; logic [2:0] param; logic [2:0] size; logic [3:0] src;
    logic [31:0] addr; logic [3:0] mask; logic [31:0] data;
  } a_t;
  typedef struct packed {
    logic [3:0] op; logic [1:0] param; logic [2:0] size; logic [3:0] src;
    logic [1:0] sink; logic den; logic [31:0] data;
  } d_t;

  localparam logic [2:0] GET = 3'd4, PUTF = 3'd0, PUTP = 3'd1;

  a_t exp_a[$];
  d_t exp_d0[$];
  d_t exp_d1[$];
  int checks = 0;
  int errors = 0;
  int stall_left = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [2:0] op, input logic [3:0] src, input logic [31:0] addr,
                        input logic [31:0] data);
    exp_a.push_back('{op: op, param: 3'd0, size: 3'd2, src: src, addr: addr, mask: 4'hF, data: data});
  endtask

  task automatic push_d(input int m, input logic [3:0] op, input logic [3:0] src,
                        input logic [1:0] sink, input logic den, input logic [31:0] data);
    d_t e;
    e = '{op: op, param: 2'd0, size: 3'd2, src: src, sink: sink, den: den, data: data};
    if (m == 0) exp_d0.push_back(e); else exp_d1.push_back(e);
  endtask

  task automatic drive_a(input int m, input logic [2:0] op, input logic [3:0] src,
                         input logic [31:0] addr, input logic [31:0] data);
    if (m == 0) begin
      m0.a_valid = 1'b1; m0.a_opcode = op; m0.a_param = 3'd0; m0.a_size = 3'd2;
      m0.a_source = src; m0.a_address = addr; m0.a_mask = 4'hF; m0.a_data = data;
    end else begin
      m1.a_valid = 1'b1; m1.a_opcode = op; m1.a_param = 3'd0; m1.a_size = 3'd2;
      m1.a_source = src; m1.a_address = addr; m1.a_mask = 4'hF; m1.a_data = data;
    end
  endtask

  task automatic drop_a(input int m);
    if (m == 0) begin
      m0.a_valid = 1'b0; m0.a_opcode = '0; m0.a_param = '0; m0.a_size = '0;
      m0.a_source = '0; m0.a_address = '0; m0.a_mask = '0; m0.a_data = '0;
    end else begin
      m1.a_valid = 1'b0; m1.a_opcode = '0; m1.a_param = '0; m1.a_size = '0;
      m1.a_source = '0; m1.a_address = '0; m1.a_mask = '0; m1.a_data = '0;
    end
  endtask

  // Returns at the negedge where the master's a_ready is seen high.
  task automatic wait_accept(input int m, input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0.a_ready : m1.a_ready) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_accept"}, 128'(got), 128'(1));
  endtask

  task automatic accept_and_drop(input int m, input string name);
    wait_accept(m, name);
    @(posedge clk); #1;
    drop_a(m);
  endtask

  task automatic drain(input string name);
    logic empty;
    empty = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_a.size() == 0 && exp_d0.size() == 0 && exp_d1.size() == 0) begin
        empty = 1'b1;
        break;
      end
    end
    check({name, "_drain"}, 128'(empty), 128'(1));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drop_a(0); drop_a(1);
    m0.d_ready = 1'b1; m1.d_ready = 1'b1;
    stall_left = 0;
    exp_a.delete(); exp_d0.delete(); exp_d1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {s.a_valid, s.d_ready, m0.d_valid, m1.d_valid, m0.a_ready, m1.a_ready,
                          grant_cnt0, grant_cnt1, s.a_address}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Slave model: accepts A (optionally stalled), answers one cycle later.
  initial begin : slave
    logic a_hs, d_hs, pending;
    a_t   pa;
    s.a_ready = 1'b0; s.d_valid = 1'b0; s.d_opcode = '0; s.d_param = '0; s.d_size = '0;
    s.d_source = '0; s.d_sink = '0; s.d_denied = 1'b0; s.d_data = '0;
    pending = 1'b0;
    pa = '0;
    forever begin
      @(negedge clk);
      a_hs = rst_n && s.a_valid && s.a_ready;
      d_hs = rst_n && s.d_valid && s.d_ready;
      if (a_hs) pa = {s.a_opcode, s.a_param, s.a_size, s.a_source, s.a_address, s.a_mask, s.a_data};
      @(posedge clk); #1;
      if (!rst_n || d_hs) begin
        s.d_valid = 1'b0; s.d_opcode = '0; s.d_size = '0; s.d_source = '0;
        s.d_sink = '0; s.d_data = '0;
      end
      if (!rst_n) pending = 1'b0;
      else if (a_hs) pending = 1'b1;
      if (pending && !s.d_valid) begin
        s.d_valid  = 1'b1;
        s.d_opcode = (pa.op == GET) ? 4'd1 : 4'd0;
        s.d_size   = pa.size;
        s.d_source = pa.src;
        s.d_sink   = 2'd1;
        s.d_data   = (pa.op == GET) ? (32'hD000_0000 | pa.addr) : 32'h0;
        pending    = 1'b0;
      end
      s.a_ready = (stall_left == 0);
      if (s.a_valid && stall_left > 0) stall_left--;
    end
  end

  initial begin : monitor
    a_t aa;
    d_t dd;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (s.a_valid && s.a_ready) begin
          aa = {s.a_opcode, s.a_param, s.a_size, s.a_source, s.a_address, s.a_mask, s.a_data};
          if (exp_a.size() == 0) check("a_unexpected", 128'(aa), 128'(0));
          else check("slave_a", 128'(aa), 128'(exp_a.pop_front()));
        end
        if (m0.d_valid && m0.d_ready) begin
          dd = {m0.d_opcode, m0.d_param, m0.d_size, m0.d_source, m0.d_sink, m0.d_denied, m0.d_data};
          if (exp_d0.size() == 0) check("m0_d_unexpected", 128'(dd), 128'(0));
          else check("m0_d", 128'(dd), 128'(exp_d0.pop_front()));
        end
        if (m1.d_valid && m1.d_ready) begin
          dd = {m1.d_opcode, m1.d_param, m1.d_size, m1.d_source, m1.d_sink, m1.d_denied, m1.d_data};
          if (exp_d1.size() == 0) check("m1_d_unexpected", 128'(dd), 128'(0));
          else check("m1_d", 128'(dd), 128'(exp_d1.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin : stim
    drop_a(0); drop_a(1);
    m0.d_ready = 1'b1; m1.d_ready = 1'b1;

    // 1: both valid from reset, m0 first, one-cycle latency to slave port
    do_reset();
    drive_a(0, GET, 4'd1, 32'h100, 32'h0);
    drive_a(1, GET, 4'd2, 32'h200, 32'h0);
    push_a(GET, 4'd1, 32'h100, 32'h0);
    push_a(GET, 4'd2, 32'h200, 32'h0);
    push_d(0, 4'd1, 4'd1, 2'd1, 1'b0, 32'hD000_0100);
    push_d(1, 4'd1, 4'd2, 2'd1, 1'b0, 32'hD000_0200);
    wait_accept(0, "t1_m0");
    check("t1_m1_not_ready", 128'(m1.a_ready), 128'(0));
    check("t1_pre_latency", 128'(s.a_valid), 128'(0));
    @(posedge clk); #1; drop_a(0);
    @(negedge clk);
    check("t1_latency", {s.a_valid, s.a_address}, {1'b1, 32'h100});
    accept_and_drop(1, "t1_m1");
    drain("t1");
    check("t1_cnts", {grant_cnt0, grant_cnt1}, {2'd1, 2'd1});

    // 2: lone m0 wins three back-to-back PUTFULL
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_a(0, PUTF, 4'(i), 32'h1000 + 32'(4 * i), 32'hCAFE_0000 + 32'(i));
      push_a(PUTF, 4'(i), 32'h1000 + 32'(4 * i), 32'hCAFE_0000 + 32'(i));
      push_d(0, 4'd0, 4'(i), 2'd1, 1'b0, 32'h0);
      accept_and_drop(0, "t2_m0");
    end
    drain("t2");
    check("t2_cnts", {grant_cnt0, grant_cnt1}, {2'd3, 2'd0});

    // 3: illegal opcode answered locally, then m0 wins the tie
    do_reset();
    drive_a(1, 3'd7, 4'd5, 32'h500, 32'h0);
    push_d(1, 4'd0, 4'd5, 2'd0, 1'b1, 32'h0);
    accept_and_drop(1, "t3_err");
    drive_a(0, GET, 4'd3, 32'h300, 32'h0);
    drive_a(1, GET, 4'd6, 32'h400, 32'h0);
    push_a(GET, 4'd3, 32'h300, 32'h0);
    push_a(GET, 4'd6, 32'h400, 32'h0);
    push_d(0, 4'd1, 4'd3, 2'd1, 1'b0, 32'hD000_0300);
    push_d(1, 4'd1, 4'd6, 2'd1, 1'b0, 32'hD000_0400);
    @(negedge clk);
    check("t3_err_no_slave", {s.a_valid, m1.d_valid, m1.d_denied}, {1'b0, 1'b1, 1'b1});
    @(posedge clk); #1;
    accept_and_drop(0, "t3_m0");
    accept_and_drop(1, "t3_m1");
    drain("t3");
    check("t3_cnts", {grant_cnt0, grant_cnt1}, {2'd1, 2'd2});

    // 4: slave stalls a_ready for 5 cycles
    do_reset();
    stall_left = 5;
    drive_a(0, PUTP, 4'd7, 32'h700, 32'h1234_5678);
    drive_a(1, GET, 4'd8, 32'h800, 32'h0);
    push_a(PUTP, 4'd7, 32'h700, 32'h1234_5678);
    push_a(GET, 4'd8, 32'h800, 32'h0);
    push_d(0, 4'd0, 4'd7, 2'd1, 1'b0, 32'h0);
    push_d(1, 4'd1, 4'd8, 2'd1, 1'b0, 32'hD000_0800);
    accept_and_drop(0, "t4_m0");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_stall", {s.a_valid, s.a_ready, s.a_address, s.a_data, s.a_source, m0.a_ready, m1.a_ready},
            {1'b1, 1'b0, 32'h700, 32'h1234_5678, 4'd7, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    accept_and_drop(1, "t4_m1");
    drain("t4");

    // 5: m0 holds off the response for 4 cycles
    do_reset();
    m0.d_ready = 1'b0;
    drive_a(0, GET, 4'd9, 32'h900, 32'h0);
    push_a(GET, 4'd9, 32'h900, 32'h0);
    push_d(0, 4'd1, 4'd9, 2'd1, 1'b0, 32'hD000_0900);
    accept_and_drop(0, "t5_m0");
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = m0.d_valid;
      end
      check("t5_d_arrives", 128'(seen), 128'(1));
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("t5_hold", {s.d_ready, m0.d_valid, m0.d_opcode, m0.d_source, m0.d_data, m1.d_valid},
            {1'b0, 1'b1, 4'd1, 4'd9, 32'hD000_0900, 1'b0});
    end
    @(posedge clk); #1;
    m0.d_ready = 1'b1;
    drain("t5");

    // 6: 2-bit counter saturation, then reset in S_WAIT
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_a(1, GET, 4'(i), 32'(64 * i), 32'h0);
      push_a(GET, 4'(i), 32'(64 * i), 32'h0);
      push_d(1, 4'd1, 4'(i), 2'd1, 1'b0, 32'hD000_0000 | 32'(64 * i));
      accept_and_drop(1, "t6_m1");
      @(negedge clk);
      check("t6_cnt1", 128'(grant_cnt1), 128'((i < 3) ? i + 1 : 3));
    end
    drain("t6a");
    m1.d_ready = 1'b0;
    drive_a(1, GET, 4'hA, 32'hA00, 32'h0);
    push_a(GET, 4'hA, 32'hA00, 32'h0);
    accept_and_drop(1, "t6_wait");
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = m1.d_valid;
      end
      check("t6_in_wait", 128'(seen), 128'(1));
    end
    rst_n = 1'b0;
    exp_a.delete(); exp_d0.delete(); exp_d1.delete();
    #1;
    check("t6_rst_outputs", {s.a_valid, s.d_ready, m0.d_valid, m1.d_valid, m1.d_data, m1.d_source,
                             grant_cnt0, grant_cnt1, s.a_address}, '0);
    m1.d_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_a(1, GET, 4'hB, 32'hB00, 32'h0);
    drive_a(0, GET, 4'hC, 32'hC00, 32'h0);
    push_a(GET, 4'hC, 32'hC00, 32'h0);
    push_a(GET, 4'hB, 32'hB00, 32'h0);
    push_d(0, 4'd1, 4'hC, 2'd1, 1'b0, 32'hD000_0C00);
    push_d(1, 4'd1, 4'hB, 2'd1, 1'b0, 32'hD000_0B00);
    wait_accept(0, "t6_post_rst_m0");
    check("t6_prio", 128'(m1.a_ready), 128'(0));
    @(posedge clk); #1; drop_a(0);
    accept_and_drop(1, "t6_post_rst_m1");
    drain("t6b");
    check("t6_final_cnts", {grant_cnt0, grant_cnt1}, {2'd1, 2'd1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
